compare_run_ctrl: RTL and testbench
===================================

COMPARE_RUN_CTRL -- requirements
Module: compare_run_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 4: number of cycles cmp_reset is held per run (1..255).
REQ-002 SHALL have parameter STOP_ON_ERROR, default 0: 1 ends the run at the first observed mismatch.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clk and aresetn.
REQ-004 SHALL have ports:
- clk  in  1  clock.
- aresetn  in  1  async reset, active low.
- start  in  1  one-cycle run request.
- abort  in  1  one-cycle run cancel.
- target_words  in  32  beats per run.
- timeout_cycles  in  32  watchdog limit; 0 disables it.
- s_axis_0_tvalid, s_axis_1_tvalid  in  1 each  upstream valids.
- s_axis_0_tready, s_axis_1_tready  out  1 each  gated readies to upstream.
- m_axis_0_tvalid, m_axis_1_tvalid  out  1 each  gated valids to the comparator.
- m_axis_0_tready, m_axis_1_tready  in  1 each  comparator readies.
- mismatch  in  1  comparator registered mismatch pulse.
- cmp_reset  out  1  comparator counter clear.
- cmp_latch  out  1  comparator result latch.
- busy, done, pass, timed_out, aborted  out  1 each  status.
- run_words, run_errors  out  32 each  run counters.
- state  out  3  FSM encoding.
REQ-005 SHALL NOT carry TDATA; only the valid/ready handshake is gated.

Function
REQ-006 SHALL implement FSM states with encodings IDLE=0, CLEAR=1, RUN=2, DRAIN=3, LATCH=4, DONE=5.
REQ-007 SHALL gate the handshake in all states except RUN: m_*_tvalid=0 and s_*_tready=0.
REQ-008 SHALL pass the handshake through combinationally in RUN: m_x_tvalid=s_x_tvalid and s_x_tready=m_x_tready.
REQ-009 SHALL define a beat as a cycle in RUN with both m_*_tvalid=1 and both m_*_tready=1.
REQ-010 In IDLE or DONE, a start with target_words!=0 SHALL go to CLEAR on the next cycle; a start with target_words=0 SHALL be ignored.
REQ-011 On CLEAR entry, SHALL zero run_words, run_errors, done, pass, timed_out and aborted, and capture target_words and timeout_cycles.
REQ-012 SHALL assert cmp_reset for exactly CLEAR_CYCLES cycles while in CLEAR, then go to RUN.
REQ-013 In RUN, each beat SHALL increment run_words; the beat that makes run_words equal the captured target SHALL move the FSM to DRAIN.
REQ-014 SHALL increment run_errors on every mismatch=1 cycle in RUN and DRAIN, saturating at 0xFFFFFFFF.
REQ-015 If STOP_ON_ERROR=1, a mismatch in RUN SHALL move the FSM to DRAIN on the next cycle.
REQ-016 SHALL stay in DRAIN exactly 2 cycles to collect late mismatch pulses, then go to LATCH.
REQ-017 In LATCH, SHALL assert cmp_latch for 1 cycle, then go to DONE.
REQ-018 In DONE, SHALL hold done=1 and pass=(run_errors==0 && !timed_out && !aborted) until the next accepted start.
REQ-019 busy SHALL be 1 in CLEAR, RUN, DRAIN and LATCH, and 0 otherwise.
REQ-020 start while busy SHALL be ignored.
REQ-021 abort in CLEAR, RUN, DRAIN or LATCH SHALL go directly to DONE with aborted=1, taking priority over any simultaneous beat completion or timeout.
REQ-022 abort in IDLE or DONE SHALL be ignored.
REQ-023 A beat and a mismatch in the same cycle SHALL both be counted.

Reset
REQ-024 aresetn=0 SHALL asynchronously force state=IDLE, all outputs to 0, and run_words=run_errors=0.
REQ-025 Reset mid-run SHALL close the gates immediately; no cmp_latch SHALL be issued.

Configuration
REQ-026 With COMPARE_RUN_CTRL_TIMEOUT_EN defined, a 32-bit idle counter SHALL reset on each beat and count RUN cycles without a beat.
REQ-027 With the macro defined, the idle counter reaching a nonzero captured timeout_cycles SHALL set timed_out=1 and go to DRAIN.
REQ-028 Without COMPARE_RUN_CTRL_TIMEOUT_EN, no idle counter SHALL exist, timeout_cycles SHALL be ignored, and timed_out SHALL be constant 0.

Verification
REQ-029 Bench SHALL cover: target=16, both valids held high, no mismatch -> cmp_reset for 4 cycles, 16 beats, cmp_latch 1 cycle, done=1, pass=1, run_words=16.
REQ-030 Bench SHALL cover: target=8, mismatch pulsed on beat 3 and 1 cycle after the last beat, STOP_ON_ERROR=0 -> run_words=8, run_errors=2, pass=0.
REQ-031 Bench SHALL cover: STOP_ON_ERROR=1, target=100, mismatch after beat 5 -> gates closed within 1 cycle, run_words<=6, run_errors=1, pass=0.
REQ-032 Bench SHALL cover: macro defined, timeout_cycles=10, s_axis_1_tvalid=0 after 3 beats -> timed_out=1 after 10 idle cycles, run_words=3, pass=0; with macro undefined -> FSM stays in RUN.
REQ-033 Bench SHALL cover: abort in the same cycle as the final beat -> aborted=1, done=1, pass=0, no cmp_latch.
REQ-034 Bench SHALL cover: aresetn low mid-RUN -> state=0, gates closed and counters 0 asynchronously, then start with target=0 -> stays IDLE.

Source files
------------

// File: rtl/compare_run_ctrl.sv
// Run controller that gates a two-stream compare: clears the comparator, passes a fixed number of beats, drains late mismatches and latches the result.
// Optional watchdog on beat-less RUN cycles is enabled by defining COMPARE_RUN_CTRL_TIMEOUT_EN.
module compare_run_ctrl #(
    parameter int CLEAR_CYCLES  = 4,
    parameter bit STOP_ON_ERROR = 1'b0
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] target_words,
    input  logic [31:0] timeout_cycles,
    input  logic        s_axis_0_tvalid,
    input  logic        s_axis_1_tvalid,
    output logic        s_axis_0_tready,
    output logic        s_axis_1_tready,
    output logic        m_axis_0_tvalid,
    output logic        m_axis_1_tvalid,
    input  logic        m_axis_0_tready,
    input  logic        m_axis_1_tready,
    input  logic        mismatch,
    output logic        cmp_reset,
    output logic        cmp_latch,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timed_out,
    output logic        aborted,
    output logic [31:0] run_words,
    output logic [31:0] run_errors,
    output logic [2:0]  state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_LATCH = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [2:0]  next_state;
    logic [7:0]  phase_cnt;
    logic [31:0] tgt_cap;
    logic        in_run;
    logic        beat;
    logic        start_ok;
    logic        hit_tgt;
    logic        stop_hit;
    logic        tmo_hit;
    logic        kill;
    logic        err_win;

    assign in_run   = (state == S_RUN);
    assign beat     = in_run & s_axis_0_tvalid & s_axis_1_tvalid & m_axis_0_tready & m_axis_1_tready;
    assign start_ok = start && (target_words != 32'd0) && ((state == S_IDLE) || (state == S_DONE));
    assign hit_tgt  = beat && (run_words + 32'd1 == tgt_cap);
    assign stop_hit = STOP_ON_ERROR && in_run && mismatch;
    assign kill     = busy && abort;
    assign err_win  = in_run || (state == S_DRAIN);

`ifdef COMPARE_RUN_CTRL_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic [31:0] tmo_cap;

    assign tmo_hit = in_run && !beat && (tmo_cap != 32'd0) && (idle_cnt + 32'd1 == tmo_cap);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            idle_cnt  <= 32'd0;
            tmo_cap   <= 32'd0;
            timed_out <= 1'b0;
        end else if (start_ok) begin
            idle_cnt  <= 32'd0;
            tmo_cap   <= timeout_cycles;
            timed_out <= 1'b0;
        end else if (in_run) begin
            idle_cnt <= beat ? 32'd0 : idle_cnt + 32'd1;
            if (tmo_hit && !abort)
                timed_out <= 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^timeout_cycles;
    assign tmo_hit    = 1'b0;
    assign timed_out  = 1'b0;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start_ok) next_state = S_CLEAR;
            S_CLEAR:        if (phase_cnt == 8'(CLEAR_CYCLES - 1)) next_state = S_RUN;
            S_RUN:          if (hit_tgt || stop_hit || tmo_hit) next_state = S_DRAIN;
            S_DRAIN:        if (phase_cnt == 8'd1) next_state = S_LATCH;
            S_LATCH:        next_state = S_DONE;
            default:        next_state = S_IDLE;
        endcase
        // Abort wins over every other exit from an active state.
        if (kill)
            next_state = S_DONE;
    end

    always_comb begin
        busy            = (state == S_CLEAR) || (state == S_RUN) || (state == S_DRAIN) || (state == S_LATCH);
        cmp_reset       = (state == S_CLEAR);
        cmp_latch       = (state == S_LATCH);
        m_axis_0_tvalid = in_run & s_axis_0_tvalid;
        m_axis_1_tvalid = in_run & s_axis_1_tvalid;
        s_axis_0_tready = in_run & m_axis_0_tready;
        s_axis_1_tready = in_run & m_axis_1_tready;
    end

    // phase_cnt restarts on every state change, so it times both CLEAR and DRAIN.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            phase_cnt  <= 8'd0;
            tgt_cap    <= 32'd0;
            run_words  <= 32'd0;
            run_errors <= 32'd0;
            done       <= 1'b0;
            pass       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            phase_cnt <= (next_state != state) ? 8'd0 : phase_cnt + 8'd1;
            if (start_ok) begin
                tgt_cap    <= target_words;
                run_words  <= 32'd0;
                run_errors <= 32'd0;
                done       <= 1'b0;
                pass       <= 1'b0;
                aborted    <= 1'b0;
            end else begin
                if (beat)
                    run_words <= run_words + 32'd1;
                if (mismatch && err_win)
                    run_errors <= sat_inc(run_errors);
                if (kill) begin
                    done    <= 1'b1;
                    pass    <= 1'b0;
                    aborted <= 1'b1;
                end else if (state == S_LATCH) begin
                    done <= 1'b1;
                    pass <= (run_errors == 32'd0) && !timed_out && !aborted;
                end
            end
        end
    end

endmodule

// File: tb/tb_compare_run_ctrl.sv
// Directed bench for compare_run_ctrl: a cycle model of the run rules checks two instances (STOP_ON_ERROR 0 and 1) every cycle, plus literal expectations per scenario.
module tb_compare_run_ctrl;

    localparam int CLR = 4;
`ifdef COMPARE_RUN_CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        clk;
    logic        aresetn;
    logic        start;
    logic        abort;
    logic [31:0] target_words;
    logic [31:0] timeout_cycles;
    logic        s0v, s1v, m0r, m1r, mismatch;

    logic        s0r [2];
    logic        s1r [2];
    logic        m0v [2];
    logic        m1v [2];
    logic        crst[2];
    logic        clat[2];
    logic        busy[2];
    logic        done[2];
    logic        pass[2];
    logic        tmo [2];
    logic        abrt[2];
    logic [31:0] rw  [2];
    logic [31:0] re  [2];
    logic [2:0]  st  [2];

    int n_cmp  = 0;
    int n_fail = 0;
    int crst_tot = 0;
    int clat_tot = 0;

    compare_run_ctrl #(.CLEAR_CYCLES(CLR), .STOP_ON_ERROR(1'b0)) dut (
        .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
        .target_words(target_words), .timeout_cycles(timeout_cycles),
        .s_axis_0_tvalid(s0v), .s_axis_1_tvalid(s1v),
        .s_axis_0_tready(s0r[0]), .s_axis_1_tready(s1r[0]),
        .m_axis_0_tvalid(m0v[0]), .m_axis_1_tvalid(m1v[0]),
        .m_axis_0_tready(m0r), .m_axis_1_tready(m1r),
        .mismatch(mismatch), .cmp_reset(crst[0]), .cmp_latch(clat[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .timed_out(tmo[0]),
        .aborted(abrt[0]), .run_words(rw[0]), .run_errors(re[0]), .state(st[0])
    );

    compare_run_ctrl #(.CLEAR_CYCLES(CLR), .STOP_ON_ERROR(1'b1)) dus (
        .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
        .target_words(target_words), .timeout_cycles(timeout_cycles),
        .s_axis_0_tvalid(s0v), .s_axis_1_tvalid(s1v),
        .s_axis_0_tready(s0r[1]), .s_axis_1_tready(s1r[1]),
        .m_axis_0_tvalid(m0v[1]), .m_axis_1_tvalid(m1v[1]),
        .m_axis_0_tready(m0r), .m_axis_1_tready(m1r),
        .mismatch(mismatch), .cmp_reset(crst[1]), .cmp_latch(clat[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .timed_out(tmo[1]),
        .aborted(abrt[1]), .run_words(rw[1]), .run_errors(re[1]), .state(st[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Run model: phase number plus a remaining-cycles countdown for timed phases.
    typedef struct {
        int     st;
        int     left;
        longint words;
        longint errs;
        longint idle;
        longint tgt;
        longint lim;
        bit     done;
        bit     pass;
        bit     tmo;
        bit     abrt;
    } mdl_t;

    mdl_t mdl[2];

    function automatic mdl_t step(mdl_t m, bit stop, bit go, bit ab, longint tw, longint tc,
                                  bit v0, bit v1, bit r0, bit r1, bit mm);
        mdl_t n = m;
        bit beat;
        bit fire;
        beat = (m.st == 2) && v0 && v1 && r0 && r1;
        if (m.st == 0 || m.st == 5) begin
            if (go && tw != 0) begin
                n = '{default: 0};
                n.st = 1; n.left = CLR; n.tgt = tw; n.lim = tc;
            end
            return n;
        end
        if (beat) n.words = (m.words + 1) % 64'h1_0000_0000;
        if (mm && (m.st == 2 || m.st == 3) && m.errs < 64'hFFFF_FFFF) n.errs = m.errs + 1;
        if (ab) begin
            n.st = 5; n.done = 1; n.abrt = 1; n.pass = 0;
            return n;
        end
        case (m.st)
            1: begin n.left = m.left - 1; if (n.left == 0) n.st = 2; end
            2: begin
                n.idle = beat ? 0 : m.idle + 1;
                fire = TMO_EN && m.lim != 0 && !beat && n.idle == m.lim;
                if (fire) n.tmo = 1;
                if ((beat && n.words == m.tgt) || (stop && mm) || fire) begin
                    n.st = 3; n.left = 2;
                end
            end
            3: begin n.left = m.left - 1; if (n.left == 0) n.st = 4; end
            4: begin n.st = 5; n.done = 1; n.pass = (m.errs == 0) && !m.tmo && !m.abrt; end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            mdl[0] <= '{default: 0};
            mdl[1] <= '{default: 0};
        end else begin
            mdl[0] <= step(mdl[0], 1'b0, start, abort, target_words, timeout_cycles, s0v, s1v, m0r, m1r, mismatch);
            mdl[1] <= step(mdl[1], 1'b1, start, abort, target_words, timeout_cycles, s0v, s1v, m0r, m1r, mismatch);
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        for (int i = 0; i < 2; i++) begin
            bit g;
            g = (mdl[i].st == 2);
            chk("state", i, st[i], mdl[i].st);
            chk("busy", i, busy[i], (mdl[i].st >= 1 && mdl[i].st <= 4));
            chk("cmp_reset", i, crst[i], mdl[i].st == 1);
            chk("cmp_latch", i, clat[i], mdl[i].st == 4);
            chk("done", i, done[i], mdl[i].done);
            chk("pass", i, pass[i], mdl[i].pass);
            chk("timed_out", i, tmo[i], mdl[i].tmo);
            chk("aborted", i, abrt[i], mdl[i].abrt);
            chk("run_words", i, rw[i], mdl[i].words);
            chk("run_errors", i, re[i], mdl[i].errs);
            chk("m0_tvalid", i, m0v[i], g & s0v);
            chk("m1_tvalid", i, m1v[i], g & s1v);
            chk("s0_tready", i, s0r[i], g & m0r);
            chk("s1_tready", i, s1r[i], g & m1r);
        end
        crst_tot += int'(crst[0]);
        clat_tot += int'(clat[0]);
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] tw, input logic [31:0] tc);
        start = 1'b1; target_words = tw; timeout_cycles = tc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_state(input int i, input int s, input int lim);
        int k = 0;
        while (st[i] != 3'(s) && k < lim) begin
            tick();
            k++;
        end
        chk("wait_state", i, st[i], s);
    endtask

    initial begin
        int c0, l0;
        aresetn = 1'b0; start = 1'b0; abort = 1'b0; mismatch = 1'b0;
        target_words = 32'd0; timeout_cycles = 32'd0;
        s0v = 1'b0; s1v = 1'b0; m0r = 1'b0; m1r = 1'b0;
        #3;
        chk("rst_state", 0, st[0], 0);
        chk("rst_busy", 0, busy[0], 0);
        chk("rst_words", 0, rw[0], 0);
        tick();
        aresetn = 1'b1;
        tick();

        // 16 clean beats
        s0v = 1'b1; s1v = 1'b1; m0r = 1'b1; m1r = 1'b1;
        c0 = crst_tot; l0 = clat_tot;
        do_start(32'd16, 32'd0);
        wait_state(0, 5, 60);
        chk("t1_words", 0, rw[0], 16);
        chk("t1_pass", 0, pass[0], 1);
        chk("t1_done", 0, done[0], 1);
        chk("t1_clear_cycles", 0, crst_tot - c0, 4);
        chk("t1_latch_cycles", 0, clat_tot - l0, 1);

        // mismatch on beat 3 and one cycle after the last beat
        do_start(32'd8, 32'd0);
        wait_state(0, 2, 10);
        for (int b = 1; b <= 8; b++) begin
            mismatch = (b == 3);
            tick();
        end
        mismatch = 1'b1;
        tick();
        mismatch = 1'b0;
        wait_state(0, 5, 10);
        chk("t2_words", 0, rw[0], 8);
        chk("t2_errors", 0, re[0], 2);
        chk("t2_pass", 0, pass[0], 0);
        chk("t2_stop_words", 1, rw[1], 3);

        // stop-on-error: mismatch arrives with beat 6
        do_start(32'd100, 32'd0);
        wait_state(1, 2, 10);
        for (int b = 1; b <= 6; b++) begin
            mismatch = (b == 6);
            tick();
        end
        mismatch = 1'b0;
        chk("t3_gate_closed", 1, m0v[1], 0);
        chk("t3_state", 1, st[1], 3);
        chk("t3_words", 1, rw[1], 6);
        wait_state(1, 5, 10);
        chk("t3_errors", 1, re[1], 1);
        chk("t3_pass", 1, pass[1], 0);
        wait_state(0, 5, 200);
        chk("t3_full_words", 0, rw[0], 100);

        // upstream 1 stalls after 3 beats
        do_start(32'd20, 32'd10);
        wait_state(0, 2, 10);
        repeat (3) tick();
        s1v = 1'b0;
`ifdef COMPARE_RUN_CTRL_TIMEOUT_EN
        repeat (9) tick();
        chk("t4_still_run", 0, st[0], 2);
        tick();
        chk("t4_drain", 0, st[0], 3);
        chk("t4_timed_out", 0, tmo[0], 1);
        wait_state(0, 5, 10);
        chk("t4_words", 0, rw[0], 3);
        chk("t4_pass", 0, pass[0], 0);
`else
        repeat (30) tick();
        chk("t4_stays_run", 0, st[0], 2);
        chk("t4_no_timeout", 0, tmo[0], 0);
        chk("t4_words", 0, rw[0], 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_aborted", 0, abrt[0], 1);
`endif
        s1v = 1'b1;

        // abort coincides with the final beat
        l0 = clat_tot;
        do_start(32'd8, 32'd0);
        wait_state(0, 2, 10);
        repeat (7) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_state", 0, st[0], 5);
        chk("t5_aborted", 0, abrt[0], 1);
        chk("t5_done", 0, done[0], 1);
        chk("t5_pass", 0, pass[0], 0);
        repeat (2) tick();
        chk("t5_no_latch", 0, clat_tot - l0, 0);

        // asynchronous reset mid-run, then zero-length start
        do_start(32'd16, 32'd0);
        wait_state(0, 2, 10);
        repeat (3) tick();
        l0 = clat_tot;
        #2 aresetn = 1'b0;
        #1;
        chk("t6_state", 0, st[0], 0);
        chk("t6_m0_tvalid", 0, m0v[0], 0);
        chk("t6_s1_tready", 0, s1r[0], 0);
        chk("t6_words", 0, rw[0], 0);
        chk("t6_errors", 0, re[0], 0);
        chk("t6_busy", 0, busy[0], 0);
        repeat (2) tick();
        aresetn = 1'b1;
        chk("t6_no_latch", 0, clat_tot - l0, 0);
        do_start(32'd0, 32'd0);
        repeat (3) tick();
        chk("t6_zero_start", 0, st[0], 0);
        chk("t6_zero_busy", 0, busy[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
